// File: rtl/lfsr_pkg.sv
// Shared constants and the single-iteration helper for the lfsr_gen family.
package lfsr_pkg;

    // Maximal-length tap masks: bit i set means state[i] feeds the XOR.
    localparam logic [7:0]  LFSR_TAPS_8  = 8'h1D;
    localparam logic [7:0]  LFSR_SEED_8  = 8'hE1;
    localparam logic [15:0] LFSR_TAPS_16 = 16'h002D;
    localparam logic [15:0] LFSR_SEED_16 = 16'hECEB;
    localparam logic [31:0] LFSR_TAPS_32 = 32'hC000_0401;
    localparam logic [31:0] LFSR_SEED_32 = 32'hACE1_ECEB;

    typedef struct packed {
        logic        out;
        logic [31:0] next;
    } lfsr_iter_t;

    // The state is zero-extended to 32 bits; feedback re-enters at bit width-1.
    function automatic lfsr_iter_t lfsr_iter(input logic [31:0] state,
                                             input logic [31:0] taps,
                                             input int          width);
        lfsr_iter_t r;
        logic       fb;
        fb     = ^(state & taps);
        r.out  = state[0];
        r.next = (state >> 1) | ({31'd0, fb} << (width - 1));
        return r;
    endfunction

endpackage

// File: rtl/lfsr_period_mon.sv
// Period monitor: counts enables since the start value was set and flags the
// update that returns the state to it.
module lfsr_period_mon
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_eff,
    input  logic [WIDTH-1:0] next_state,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len
);

    logic [WIDTH-1:0] start_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_inc_s;
    logic             done_r;
    logic [WIDTH-1:0] len_r;

    // Saturating increment of the enable count.
    always_comb begin
        if (cnt_r == {WIDTH{1'b1}}) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Start value, counter and period result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_r <= SEED;
            cnt_r   <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
            len_r   <= {WIDTH{1'b0}};
        end else if (load) begin
            start_r <= load_eff;
            cnt_r   <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else if (en) begin
            if (next_state == start_r) begin
                done_r <= 1'b1;
                len_r  <= cnt_inc_s;
                cnt_r  <= {WIDTH{1'b0}};
            end else begin
                done_r <= 1'b0;
                cnt_r  <= cnt_inc_s;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign period_done = done_r;
    assign period_len  = len_r;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR producing STEP bits per enable.
// Optional period monitor enabled by defining LFSR_PERIOD_MON_EN.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_16,
    parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_16,
    parameter int               STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [STEP-1:0]  rand_bits,
    output logic [WIDTH-1:0] shift_reg,
    output logic             zero_seed,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len
);

    logic [WIDTH-1:0] shift_reg_r;
    logic [STEP-1:0]  rand_bits_r;
    logic             zero_seed_r;
    logic [WIDTH-1:0] adv_s;
    logic [STEP-1:0]  bits_s;
    logic [WIDTH-1:0] load_eff_s;
    logic             zero_load_s;
    lfsr_iter_t       it_s;

    // Unrolled STEP iterations; iteration i's out bit lands in bits_s[i].
    always_comb begin
        adv_s  = shift_reg_r;
        bits_s = {STEP{1'b0}};
        it_s   = '0;
        for (int i = 0; i < STEP; i++) begin
            it_s      = lfsr_iter(32'(adv_s), 32'(TAPS), WIDTH);
            bits_s[i] = it_s.out;
            adv_s     = it_s.next[WIDTH-1:0];
        end
    end

    // An all-zero load would lock the LFSR, so SEED is substituted.
    always_comb begin
        zero_load_s = (load_val == {WIDTH{1'b0}});
        if (zero_load_s) begin
            load_eff_s = SEED;
        end else begin
            load_eff_s = load_val;
        end
    end

    // State, output bits and zero-seed pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg_r <= SEED;
            rand_bits_r <= {STEP{1'b0}};
            zero_seed_r <= 1'b0;
        end else if (load) begin
            shift_reg_r <= load_eff_s;
            zero_seed_r <= zero_load_s;
        end else if (en) begin
            shift_reg_r <= adv_s;
            rand_bits_r <= bits_s;
            zero_seed_r <= 1'b0;
        end else begin
            zero_seed_r <= 1'b0;
        end
    end

    assign shift_reg = shift_reg_r;
    assign rand_bits = rand_bits_r;
    assign zero_seed = zero_seed_r;

`ifdef LFSR_PERIOD_MON_EN
    lfsr_period_mon #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_period_mon (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .load_eff    (load_eff_s),
        .next_state  (adv_s),
        .period_done (period_done),
        .period_len  (period_len)
    );
`else
    assign period_done = 1'b0;
    assign period_len  = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: a STEP=1 and a STEP=4 instance against a
// single-iteration reference model.
module tb_lfsr_gen;

    localparam logic [15:0] SEED = 16'hECEB;
    localparam logic [15:0] TAPS = 16'h002D;

    typedef struct {
        logic [15:0] sr;
        logic        b;
        logic        zs;
        logic        pd;
        logic [15:0] pl;
        logic [15:0] sr4;
        logic [3:0]  b4;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en1, load1, en4, load4;
    logic [15:0] val1, val4;
    logic [0:0]  rb1;
    logic [3:0]  rb4;
    logic [15:0] sr1, sr4, pl1, pl4;
    logic        zs1, zs4, pd1, pd4;

    int n_cmp;
    int n_err;
    exp_t sb_q[$];

    // Model state
    logic [15:0] m_sr, m_start, m_cnt, m_len, m_sr4;
    logic        m_b, m_zs, m_pd;
    logic [3:0]  m_b4;

    lfsr_gen dut1 (
        .clk(clk), .rst(rst), .en(en1), .load(load1), .load_val(val1),
        .rand_bits(rb1), .shift_reg(sr1), .zero_seed(zs1),
        .period_done(pd1), .period_len(pl1)
    );

    lfsr_gen #(.STEP(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .load(load4), .load_val(val4),
        .rand_bits(rb4), .shift_reg(sr4), .zero_seed(zs4),
        .period_done(pd4), .period_len(pl4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ref_iter(input logic [15:0] s, output logic [15:0] n, output logic o);
        logic fb;
        o  = s[0];
        fb = ^(s & TAPS);
        n  = {fb, s[15:1]};
    endtask

    task automatic model_reset();
        m_sr = SEED; m_b = 1'b0; m_zs = 1'b0; m_pd = 1'b0;
        m_start = SEED; m_cnt = 16'd0; m_len = 16'd0;
        m_sr4 = SEED; m_b4 = 4'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sr"}, 32'(sr1), 32'(SEED));
        check({tag, "_rb"}, 32'(rb1), 32'd0);
        check({tag, "_zs"}, 32'(zs1), 32'd0);
        check({tag, "_pd"}, 32'(pd1), 32'd0);
        check({tag, "_pl"}, 32'(pl1), 32'd0);
        check({tag, "_sr4"}, 32'(sr4), 32'(SEED));
        check({tag, "_rb4"}, 32'(rb4), 32'd0);
    endtask

    // One clock: drive inputs, push the model's expectation, then compare.
    task automatic tick(input logic e1, input logic l1, input logic [15:0] v1, input logic e4);
        exp_t        x;
        logic [15:0] n;
        logic        o;
        logic [15:0] inc;
        en1 = e1; load1 = l1; val1 = v1; en4 = e4; load4 = 1'b0; val4 = 16'd0;
        if (l1) begin
            m_sr    = (v1 == 16'd0) ? SEED : v1;
            m_zs    = (v1 == 16'd0);
            m_pd    = 1'b0;
            m_start = m_sr;
            m_cnt   = 16'd0;
        end else if (e1) begin
            ref_iter(m_sr, n, o);
            m_sr = n; m_b = o; m_zs = 1'b0;
            inc = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            if (m_sr == m_start) begin
                m_pd = 1'b1; m_len = inc; m_cnt = 16'd0;
            end else begin
                m_pd = 1'b0; m_cnt = inc;
            end
        end else begin
            m_zs = 1'b0; m_pd = 1'b0;
        end
        if (e4) begin
            for (int i = 0; i < 4; i++) begin
                ref_iter(m_sr4, n, o);
                m_sr4 = n; m_b4[i] = o;
            end
        end
        x.sr = m_sr; x.b = m_b; x.zs = m_zs; x.sr4 = m_sr4; x.b4 = m_b4;
`ifdef LFSR_PERIOD_MON_EN
        x.pd = m_pd; x.pl = m_len;
`else
        x.pd = 1'b0; x.pl = 16'd0;
`endif
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        check("sr",  32'(sr1), 32'(x.sr));
        check("rb",  32'(rb1), 32'(x.b));
        check("zs",  32'(zs1), 32'(x.zs));
        check("pd",  32'(pd1), 32'(x.pd));
        check("pl",  32'(pl1), 32'(x.pl));
        check("sr4", 32'(sr4), 32'(x.sr4));
        check("rb4", 32'(rb4), 32'(x.b4));
    endtask

    // Asynchronous reset between edges; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        en1 = 1'b0; load1 = 1'b0; en4 = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; en1 = 1'b0; load1 = 1'b0; val1 = 16'd0;
        en4 = 1'b0; load4 = 1'b0; val4 = 16'd0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");

        tick(1'b1, 1'b0, 16'd0, 1'b0);
        check("first_step_sr", 32'(sr1), 32'h0000_F675);
        check("first_step_rb", 32'(rb1), 32'd1);

        tick(1'b0, 1'b1, 16'h0000, 1'b0);
        check("zero_load_sr", 32'(sr1), 32'(SEED));
        check("zero_load_zs", 32'(zs1), 32'd1);
        tick(1'b0, 1'b0, 16'h0000, 1'b0);
        check("zero_seed_one_cycle", 32'(zs1), 32'd0);

        tick(1'b1, 1'b1, 16'h1234, 1'b0);
        check("load_over_en", 32'(sr1), 32'h0000_1234);

        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 16'd0, 1'b0);
        tick(1'b0, 1'b1, 16'h8001, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 16'd0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            int gap;
            tick(1'b0, 1'b0, 16'd0, 1'b1);
            gap = int'($urandom_range(3, 0));
            for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 16'd0, 1'b0);
        end

        for (int k = 0; k < 20; k++) tick(1'b1, 1'b0, 16'd0, 1'b1);
        async_reset("async_rst");
        tick(1'b1, 1'b0, 16'd0, 1'b1);
        check("after_rst_sr", 32'(sr1), 32'h0000_F675);

`ifdef LFSR_PERIOD_MON_EN
        async_reset("period_restart");
        for (int k = 0; k < 2000; k++) tick(1'b1, 1'b0, 16'd0, 1'b0);
        async_reset("period_mid_rst");
        for (int k = 0; k < 65534; k++) tick(1'b1, 1'b0, 16'd0, 1'b0);
        check("pre_period_pd", 32'(pd1), 32'd0);
        tick(1'b1, 1'b0, 16'd0, 1'b0);
        check("period_sr",  32'(sr1), 32'(SEED));
        check("period_pd",  32'(pd1), 32'd1);
        check("period_len", 32'(pl1), 32'h0000_FFFF);
        tick(1'b0, 1'b0, 16'd0, 1'b0);
        check("period_pd_pulse", 32'(pd1), 32'd0);
        check("period_len_hold", 32'(pl1), 32'h0000_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random source, successor to the fixed 16-bit single-bit LFSR. Produces STEP pseudo-random bits per enable from a WIDTH-bit register with a configurable tap mask, runtime seed loading and an optional period monitor. Used by verification stimulus and by RTL that needs cheap randomness, such as replacement policies and arbitration tie-breaks.

## Interface
- WIDTH, 16: state width, 3..32.
- TAPS, 16'h002D: feedback mask, bit i set means state[i] feeds the XOR; default taps are bits 0,2,3,5.
- SEED, 16'hECEB: reset value, and the substitute for an all-zero load; must be non-zero.
- STEP, 1: LFSR iterations per enable, 1..WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- en  in  1  advance the LFSR by STEP iterations this cycle.
- load  in  1  load load_val into the state; priority over en.
- load_val  in  WIDTH  seed value to load.
- rand_bits  out  STEP  bits shifted out by the last enabled update; registered.
- shift_reg  out  WIDTH  current state; registered.
- zero_seed  out  1  one-cycle pulse: a load of 0 was replaced by SEED.
- period_done  out  1  one-cycle pulse: state returned to its start value (LFSR_PERIOD_MON_EN only).
- period_len  out  WIDTH  enables counted for the last completed period (LFSR_PERIOD_MON_EN only).

## Operation
- One iteration: out = s[0]; fb = ^(s & TAPS); s = {fb, s[WIDTH-1:1]}.
- For each enable, run STEP iterations combinationally in one cycle.
  - rand_bits[i] is the out bit of iteration i; iteration 0 goes to the LSB.
- Priority is rst > load > en > hold.
- load with load_val != 0: shift_reg <= load_val, rand_bits unchanged, zero_seed <= 0.
- load with load_val == 0: shift_reg <= SEED, zero_seed <= 1 for one cycle.
- en without load: shift_reg and rand_bits update.
- Idle cycle: shift_reg, rand_bits and period_len hold; zero_seed and period_done return to 0.
- The state can never become all-zero, given a non-zero SEED and the zero-load substitution.

## Timing
- Reset values: shift_reg = SEED, rand_bits = 0, zero_seed = 0, period_done = 0, period_len = 0.
- Latency: an update is visible on outputs the cycle after en or load is sampled high. There is no handshake and no backpressure.
- Back-to-back en in consecutive cycles advances on every cycle.
- rst asserted mid-stream returns all outputs to their reset values immediately, without waiting for a clock edge. The period monitor restarts from SEED.

## Configuration
- Macro: LFSR_PERIOD_MON_EN.
- Defined:
  - Start value = SEED after reset, or the effective loaded value after a load.
  - A WIDTH-bit counter counts enables since the start value was set.
  - When an enabled update produces shift_reg == start value: period_done pulses with that update, period_len <= count (including this enable), and the counter clears.
  - load clears the counter and sets a new start value. It does not pulse period_done.
  - The counter saturates at all-ones.
- Not defined: period_done and period_len are tied to 0 and no counter logic exists.

## Structure
- Package lfsr_pkg holds:
  - the default TAPS/SEED constants for widths 8, 16 and 32;
  - the function lfsr_iter(state, taps), which returns the next state and the out bit.
- Sub-module lfsr_period_mon holds the start-value register, the counter and the comparator. It is instantiated only under LFSR_PERIOD_MON_EN.

## Test plan
- Reset with defaults -> shift_reg = 16'hECEB, rand_bits = 0, all pulses 0.
- Single en from reset -> shift_reg = 16'hF675, rand_bits = 1.
- load = 1, load_val = 0 -> next cycle shift_reg = 16'hECEB and zero_seed high for exactly one cycle. load and en in the same cycle with load_val = 16'h1234 -> shift_reg = 16'h1234, no advance.
- STEP = 4 against a STEP = 1 reference model: after every en, state equals four reference iterations, and rand_bits[0..3] equal the reference bits in order. Use random idle gaps of 0-3 cycles.
- LFSR_PERIOD_MON_EN, defaults, 65535 enables -> shift_reg = 16'hECEB, period_done pulses on the final update, period_len = 16'hFFFF.
- Assert rst asynchronously midway through the period run -> outputs reset without waiting for a clock edge. A fresh 65535-enable run still reports period_len = 16'hFFFF.
